// File: rtl/datapath_if.sv
// datapath_if: instruction/result bundle between the control/decode unit and
// the register-file datapath.
//   opcode     4       operation select
//   src_reg    ADDR_W  source register index (rs)
//   dest_reg   ADDR_W  destination register index (rd), also second operand
//   immediate  DATA_W  immediate operand
//   result     DATA_W  registered copy of the last value written to rd
//   zero_flag  1       (DATAPATH_FLAGS_EN only) last written value was zero
//   carry_flag 1       (DATAPATH_FLAGS_EN only) carry/borrow/shifted-out bit
// Modports: master = control/decode unit, slave = datapath.
interface datapath_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dest_reg;
  logic [DATA_W-1:0] immediate;
  logic [DATA_W-1:0] result;
`ifdef DATAPATH_FLAGS_EN
  logic              zero_flag;
  logic              carry_flag;
`endif

`ifdef DATAPATH_FLAGS_EN
  modport master (
    output opcode, src_reg, dest_reg, immediate,
    input  result, zero_flag, carry_flag
  );
  modport slave (
    input  opcode, src_reg, dest_reg, immediate,
    output result, zero_flag, carry_flag
  );
`else
  modport master (
    output opcode, src_reg, dest_reg, immediate,
    input  result
  );
  modport slave (
    input  opcode, src_reg, dest_reg, immediate,
    output result
  );
`endif
endinterface

// File: rtl/datapath.sv
// datapath: single-cycle 8 x 16-bit register file plus ALU. Each clock one
// decoded instruction reads rs/rd combinationally (old values), and the ALU
// output is written to rd and registered onto result on the same edge.
// Ports:
//   clk    in   system clock, rising-edge
//   reset  in   synchronous, active-high; clears registers, result and flags
//   bus    datapath_if.slave (opcode, src_reg, dest_reg, immediate in;
//          result, and optionally zero_flag/carry_flag, out)
// Optional feature macro: DATAPATH_FLAGS_EN adds registered zero/carry flags.
module datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  datapath_if.slave   bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_LOAD = 4'b0001,
    OP_MOV  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SUB  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_NOT  = 4'b1000,
    OP_SHL  = 4'b1001,
    OP_SHR  = 4'b1010,
    OP_ADDI = 4'b1011
  } op_e;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0] rs_val, rd_val, alu_val;
  logic              wr_en;
  op_e               op;

  assign op     = op_e'(bus.opcode);
  assign rs_val = regs_q[bus.src_reg];
  assign rd_val = regs_q[bus.dest_reg];

  always_comb begin
    alu_val = '0;
    wr_en   = 1'b1;
    case (op)
      OP_LOAD: alu_val = bus.immediate;
      OP_MOV:  alu_val = rs_val;
      OP_ADD:  alu_val = rd_val + rs_val;
      OP_XOR:  alu_val = rd_val ^ rs_val;
      OP_SUB:  alu_val = rd_val - rs_val;
      OP_AND:  alu_val = rd_val & rs_val;
      OP_OR:   alu_val = rd_val | rs_val;
      OP_NOT:  alu_val = ~rs_val;
      OP_SHL:  alu_val = {rs_val[DATA_W-2:0], 1'b0};
      OP_SHR:  alu_val = {1'b0, rs_val[DATA_W-1:1]};
      OP_ADDI: alu_val = rd_val + bus.immediate;
      default: wr_en   = 1'b0;  // NOP and reserved opcodes
    endcase
  end

  always_comb begin
    regs_d   = regs_q;
    result_d = result_q;
    if (wr_en) begin
      regs_d[bus.dest_reg] = alu_val;
      result_d             = alu_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      result_q <= '0;
    end else begin
      regs_q   <= regs_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

`ifdef DATAPATH_FLAGS_EN
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [DATA_W:0]   add_ext;
  logic [DATA_W-1:0] add_opnd;

  // ADD and ADDI share one widened adder so the carry-out is bit DATA_W.
  assign add_opnd = (op == OP_ADDI) ? bus.immediate : rs_val;
  assign add_ext  = {1'b0, rd_val} + {1'b0, add_opnd};

  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    if (wr_en) begin
      zero_d = (alu_val == '0);
      case (op)
        OP_ADD, OP_ADDI: carry_d = add_ext[DATA_W];
        OP_SUB:          carry_d = (rd_val < rs_val);
        OP_SHL:          carry_d = rs_val[DATA_W-1];
        OP_SHR:          carry_d = rs_val[0];
        default:         carry_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
`endif
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed-vector bench for datapath. Each vector issues one
// instruction, waits one edge and compares result (and the flags when
// DATAPATH_FLAGS_EN is defined) with hand-computed values. Register contents
// are observed non-destructively with MOV Rn <- Rn.
module tb_datapath;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam logic [3:0] NOP  = 4'b0000, LOAD = 4'b0001, MOV = 4'b0010,
                         ADD  = 4'b0011, XOR  = 4'b0100, SUB = 4'b0101,
                         AND_ = 4'b0110, OR_  = 4'b0111, NOT_ = 4'b1000,
                         SHL  = 4'b1001, SHR  = 4'b1010, ADDI = 4'b1011,
                         RSV  = 4'b1101;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, clock it in, then compare just after the edge.
  task automatic issue(input string tag, input logic [3:0] op,
                       input logic [2:0] rs, input logic [2:0] rd,
                       input logic [15:0] imm, input logic [15:0] exp_res,
                       input logic exp_z, input logic exp_c);
    bus.opcode    = op;
    bus.src_reg   = rs;
    bus.dest_reg  = rd;
    bus.immediate = imm;
    @(posedge clk);
    #1;
    check(tag, bus.result, exp_res);
`ifdef DATAPATH_FLAGS_EN
    check({tag, "_z"}, {15'd0, bus.zero_flag}, {15'd0, exp_z});
    check({tag, "_c"}, {15'd0, bus.carry_flag}, {15'd0, exp_c});
`else
    if (exp_z === 1'bx && exp_c === 1'bx) $display("unreachable");
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.opcode = NOP; bus.src_reg = '0; bus.dest_reg = '0; bus.immediate = '0;

    // 1: reset then NOP; every register reads back zero
    issue("rst", NOP, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    issue("nop0", NOP, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      issue($sformatf("r%0d_rst", i), MOV, 3'(i), 3'(i), 16'h0, 16'h0000, 1'b1, 1'b0);

    // 2: load / move / add / xor chain
    issue("load_r1", LOAD, 0, 1, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
    issue("mov_r2",  MOV,  1, 2, 16'h0000, 16'h00FF, 1'b0, 1'b0);
    issue("add_r2",  ADD,  1, 2, 16'h0000, 16'h01FE, 1'b0, 1'b0);
    issue("xor_r2",  XOR,  1, 2, 16'h0000, 16'h0101, 1'b0, 1'b0);

    // 3: wrap-around add-immediate and borrowing subtract
    issue("load_r3", LOAD, 0, 3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    issue("addi_r3", ADDI, 0, 3, 16'h0001, 16'h0000, 1'b1, 1'b1);
    issue("sub_r3",  SUB,  1, 3, 16'h0000, 16'hFF01, 1'b0, 1'b1);
    issue("sub_nb",  SUB,  1, 3, 16'h0000, 16'hFE02, 1'b0, 1'b0);

    // 4: shifts and NOT
    issue("load_r4", LOAD, 0, 4, 16'h8001, 16'h8001, 1'b0, 1'b0);
    issue("shl_r5",  SHL,  4, 5, 16'h0000, 16'h0002, 1'b0, 1'b1);
    issue("shr_r6",  SHR,  4, 6, 16'h0000, 16'h4000, 1'b0, 1'b1);
    issue("not_r7",  NOT_, 4, 7, 16'h0000, 16'h7FFE, 1'b0, 1'b0);

    // 5: reserved opcode and NOP hold result, flags and registers
    issue("rsv",     RSV,  1, 4, 16'hABCD, 16'h7FFE, 1'b0, 1'b0);
    issue("nop1",    NOP,  1, 4, 16'hABCD, 16'h7FFE, 1'b0, 1'b0);
    issue("r4_hold", MOV,  4, 4, 16'h0000, 16'h8001, 1'b0, 1'b0);

    // R0 is writable; AND/OR; same-register operands
    issue("load_r0", LOAD, 0, 0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0);
    issue("and_r0",  AND_, 4, 0, 16'h0000, 16'h0001, 1'b0, 1'b0);
    issue("or_r0",   OR_,  6, 0, 16'h0000, 16'h4001, 1'b0, 1'b0);
    issue("add_r1x2", ADD, 1, 1, 16'h0000, 16'h01FE, 1'b0, 1'b0);
    issue("add_cy",  ADD,  4, 4, 16'h0000, 16'h0002, 1'b0, 1'b1);
    issue("xor_r1x", XOR,  1, 1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    issue("r6_hold", MOV,  6, 6, 16'h0000, 16'h4000, 1'b0, 1'b0);

    // 6: reset wins over a simultaneous LOAD
    reset = 1'b1;
    issue("rst_load", LOAD, 0, 1, 16'h1234, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    issue("r1_clr",  MOV,  1, 1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    issue("r6_clr",  MOV,  6, 6, 16'h0000, 16'h0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
